// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: load/settle/unload sequencer around the combinational fft8 core.
// Optional FFT8_SEQ_CTRL_IFFT_EN adds an inv port (re/im swap for the inverse transform).
module fft8_seq_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_re,
    input  logic [31:0]  in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_re,
    output logic [31:0]  out_im,
    output logic         out_last,
    output logic         out_exc,
    output logic         exc_sticky,
    input  logic         exc_clr,
    output logic         busy,
    output logic [255:0] fft_a_re,
    output logic [255:0] fft_a_im,
    output logic [127:0] fft_w_re,
    output logic [127:0] fft_w_im,
    input  logic [255:0] fft_c_re,
    input  logic [255:0] fft_c_im,
    input  logic         fft_exc
`ifdef FFT8_SEQ_CTRL_IFFT_EN
    ,
    input  logic         inv
`endif
);
    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_UNLOAD} state_t;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    state_t           r_state, w_next;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_ld_re [8];
    logic [31:0]      r_ld_im [8];
    logic [31:0]      r_res_re [8];
    logic [31:0]      r_res_im [8];
    logic             r_out_exc, r_exc_sticky;
    logic             w_acc, w_cap, w_hs, w_in_swap, w_out_swap;
`ifdef FFT8_SEQ_CTRL_IFFT_EN
    logic             r_inv;
    // The first sample of a frame uses inv directly; later samples use the held copy.
    assign w_in_swap  = (r_idx == 3'd0) ? inv : r_inv;
    assign w_out_swap = r_inv;
`else
    assign w_in_swap  = 1'b0;
    assign w_out_swap = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state;
        w_acc     = 1'b0;
        w_cap     = 1'b0;
        w_hs      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                w_acc    = in_valid;
                if (w_acc && r_idx == 3'd7) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy  = 1'b1;
                w_cap = (r_cnt == SETTLE_LAST);
                if (w_cap) w_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                w_hs      = out_ready;
                if (w_hs && r_idx == 3'd7) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_out_exc    <= 1'b0;
            r_exc_sticky <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_ld_re[k]  <= '0;
                r_ld_im[k]  <= '0;
                r_res_re[k] <= '0;
                r_res_im[k] <= '0;
            end
`ifdef FFT8_SEQ_CTRL_IFFT_EN
            r_inv        <= 1'b0;
`endif
        end else begin
            if (w_acc || w_hs) r_idx <= r_idx + 3'd1;
            r_cnt <= (r_state == S_SETTLE) ? r_cnt + 1'b1 : '0;
            if (w_acc) begin
                r_ld_re[r_idx] <= w_in_swap ? in_im : in_re;
                r_ld_im[r_idx] <= w_in_swap ? in_re : in_im;
            end
`ifdef FFT8_SEQ_CTRL_IFFT_EN
            if (w_acc && r_idx == 3'd0) r_inv <= inv;
`endif
            if (w_cap) begin
                for (int k = 0; k < 8; k++) begin
                    r_res_re[k] <= fft_c_re[32*k +: 32];
                    r_res_im[k] <= fft_c_im[32*k +: 32];
                end
                r_out_exc <= fft_exc;
            end
            // A capture raising the exception beats a simultaneous clear.
            r_exc_sticky <= (r_exc_sticky & ~exc_clr) | (w_cap & fft_exc);
        end
    end
    for (genvar k = 0; k < 8; k++) begin : g_a
        assign fft_a_re[32*k +: 32] = r_ld_re[k];
        assign fft_a_im[32*k +: 32] = r_ld_im[k];
    end
    assign fft_w_re   = {32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
    assign fft_w_im   = {32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};
    assign out_re     = w_out_swap ? r_res_im[r_idx] : r_res_re[r_idx];
    assign out_im     = w_out_swap ? r_res_re[r_idx] : r_res_im[r_idx];
    assign out_last   = out_valid && (r_idx == 3'd7);
    assign out_exc    = r_out_exc;
    assign exc_sticky = r_exc_sticky;
endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// tb_fft8_seq_ctrl: directed bench for fft8_seq_ctrl with a behavioural stand-in for the fft8 core.
// Define FFT8_SEQ_CTRL_IFFT_EN to also exercise the inverse-transform path.
module tb_fft8_seq_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0, exc_clr = 1'b0;
    logic [31:0]  in_re = '0, in_im = '0;
    logic         in_ready, out_valid, out_last, out_exc, exc_sticky, busy;
    logic [31:0]  out_re, out_im;
    logic [255:0] fft_a_re, fft_a_im, fft_c_re, fft_c_im;
    logic [127:0] fft_w_re, fft_w_im;
    logic         fft_exc, dc;
`ifdef FFT8_SEQ_CTRL_IFFT_EN
    logic         inv = 1'b0;
`endif
    int           n_pass = 0, n_total = 0;
    logic [31:0]  f_re [8], f_im [8], g_re [8], g_im [8];
    logic         g_last [8], g_exc [8];
    int           hs, lat;
    bit           bad_stab, bad_rdy;

    fft8_seq_ctrl #(.SETTLE_CYC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .out_exc(out_exc),
        .exc_sticky(exc_sticky), .exc_clr(exc_clr), .busy(busy),
        .fft_a_re(fft_a_re), .fft_a_im(fft_a_im), .fft_w_re(fft_w_re), .fft_w_im(fft_w_im),
        .fft_c_re(fft_c_re), .fft_c_im(fft_c_im), .fft_exc(fft_exc)
`ifdef FFT8_SEQ_CTRL_IFFT_EN
        , .inv(inv)
`endif
    );

    always #5 clk = ~clk;

    // Core stand-in: an exact DFT for the all-ones frame and for frames where only x0 matters
    // (impulse); any other frame simply broadcasts x0. Exception = any NaN on the inputs.
    always_comb begin
        dc       = 1'b1;
        fft_exc  = 1'b0;
        fft_c_re = '0;
        fft_c_im = '0;
        for (int k = 0; k < 8; k++) begin
            dc = dc && fft_a_re[32*k +: 32] == 32'h3F800000 && fft_a_im[32*k +: 32] == 32'h0;
            fft_exc = fft_exc || (fft_a_re[32*k+23 +: 8] == 8'hFF && fft_a_re[32*k +: 23] != 23'h0)
                              || (fft_a_im[32*k+23 +: 8] == 8'hFF && fft_a_im[32*k +: 23] != 23'h0);
        end
        for (int k = 0; k < 8; k++) begin
            fft_c_re[32*k +: 32] = dc ? ((k == 0) ? 32'h41000000 : 32'h0) : fft_a_re[31:0];
            fft_c_im[32*k +: 32] = dc ? 32'h0 : fft_a_im[31:0];
        end
    end

    task automatic set_impulse(input logic [31:0] re0, input logic [31:0] im0);
        for (int i = 0; i < 8; i++) begin
            f_re[i] = (i == 0) ? re0 : 32'h0;
            f_im[i] = (i == 0) ? im0 : 32'h0;
        end
    endtask

    task automatic send_frame;
        for (int i = 0; i < 8; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_re    = f_re[i];
            in_im    = f_im[i];
            while (!in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (t == 100) begin
                n_total++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int e);
        e = 0;
        while (!out_valid && e < 50) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    task automatic recv(input bit bp);
        int c = 0;
        bit stalled = 0;
        logic [31:0] p_re = '0, p_im = '0;
        logic p_last = 1'b0;
        hs = 0; bad_stab = 0; bad_rdy = 0;
        while (hs < 8 && c < 200) begin
            out_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            if (stalled && (out_re !== p_re || out_im !== p_im || out_last !== p_last || out_valid !== 1'b1))
                bad_stab = 1;
            if (in_ready) bad_rdy = 1;
            if (out_valid && out_ready) begin
                g_re[hs] = out_re; g_im[hs] = out_im; g_last[hs] = out_last; g_exc[hs] = out_exc;
                hs++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                p_re = out_re; p_im = out_im; p_last = out_last;
            end
            c++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_last !== 1'b0 || out_exc !== 1'b0 || exc_sticky !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_flags: last=%b exc=%b sticky=%b busy=%b want 0000", out_last, out_exc, exc_sticky, busy);
        else n_pass++;
        n_total++; if (out_re !== 32'h0 || out_im !== 32'h0) $display("FAIL rst_out_data: got %h/%h want 0/0", out_re, out_im); else n_pass++;
        n_total++; if (fft_a_re !== 256'h0 || fft_a_im !== 256'h0) $display("FAIL rst_load_buf: got %h / %h want 0", fft_a_re, fft_a_im); else n_pass++;
        n_total++; if (fft_w_re !== 128'hBF3504F3_00000000_3F3504F3_3F800000)
            $display("FAIL twiddle_re: got %h want BF3504F3000000003F3504F33F800000", fft_w_re);
        else n_pass++;
        n_total++; if (fft_w_im !== 128'hBF3504F3_BF800000_BF3504F3_00000000)
            $display("FAIL twiddle_im: got %h want BF3504F3BF800000BF3504F300000000", fft_w_im);
        else n_pass++;
    endtask

    task automatic test_impulse;
        set_impulse(32'h3F800000, 32'h0);
        send_frame();
        n_total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL settle_flags: busy=%b in_ready=%b want 1/0", busy, in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL settle_early_valid: got %b want 0", out_valid); else n_pass++;
        wait_valid(lat);
        n_total++; if (lat != 4) $display("FAIL impulse_latency: got %0d edges want 4", lat); else n_pass++;
        recv(1'b0);
        n_total++; if (hs != 8) $display("FAIL impulse_count: got %0d handshakes want 8", hs); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (g_re[i] !== 32'h3F800000 || (g_im[i] & 32'h7FFFFFFF) !== 32'h0 || g_last[i] !== (i == 7) || g_exc[i] !== 1'b0)
                $display("FAIL impulse_out%0d: got re=%h im=%h last=%b exc=%b want 3f800000 +-0 %b 0", i, g_re[i], g_im[i], g_last[i], g_exc[i], i == 7);
            else n_pass++;
        end
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL impulse_reload: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_load_map;
        for (int i = 0; i < 8; i++) begin
            f_re[i] = 32'h10000000 + i;
            f_im[i] = 32'h20000000 + i;
        end
        send_frame();
        // Junk offered during SETTLE/UNLOAD must be ignored.
        in_valid = 1'b1; in_re = 32'hDEADBEEF; in_im = 32'hCAFEF00D;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (fft_a_re[32*i +: 32] !== 32'h10000000 + i || fft_a_im[32*i +: 32] !== 32'h20000000 + i)
                $display("FAIL load_slot%0d: got %h/%h want %h/%h", i, fft_a_re[32*i +: 32], fft_a_im[32*i +: 32], 32'h10000000 + i, 32'h20000000 + i);
            else n_pass++;
        end
        wait_valid(lat);
        recv(1'b0);
        in_valid = 1'b0;
        n_total++; if (fft_a_re[255:224] !== 32'h10000007 || fft_a_re[31:0] !== 32'h10000000)
            $display("FAIL load_frozen: slot7=%h slot0=%h want 10000007/10000000", fft_a_re[255:224], fft_a_re[31:0]);
        else n_pass++;
        n_total++; if (g_re[5] !== 32'h10000000 || g_im[5] !== 32'h20000000)
            $display("FAIL load_passthru: got %h/%h want 10000000/20000000", g_re[5], g_im[5]);
        else n_pass++;
    endtask

    task automatic test_dc;
        for (int i = 0; i < 8; i++) begin f_re[i] = 32'h3F800000; f_im[i] = 32'h0; end
        send_frame();
        wait_valid(lat);
        recv(1'b0);
        n_total++; if (g_re[0] !== 32'h41000000 || (g_im[0] & 32'h7FFFFFFF) !== 32'h0)
            $display("FAIL dc_bin0: got %h/%h want 41000000/+-0", g_re[0], g_im[0]);
        else n_pass++;
        for (int i = 1; i < 8; i++) begin
            n_total++;
            if ((g_re[i] & 32'h7FFFFFFF) !== 32'h0 || (g_im[i] & 32'h7FFFFFFF) !== 32'h0)
                $display("FAIL dc_bin%0d: got %h/%h want +-0/+-0", i, g_re[i], g_im[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        set_impulse(32'h3F800000, 32'h0);
        send_frame();
        wait_valid(lat);
        recv(1'b1);
        n_total++; if (hs != 8) $display("FAIL bp_count: got %0d handshakes want 8", hs); else n_pass++;
        n_total++; if (bad_stab) $display("FAIL bp_stable: outputs changed while stalled, got 1 want 0"); else n_pass++;
        n_total++; if (bad_rdy) $display("FAIL bp_in_ready: in_ready rose before last handshake, got 1 want 0"); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_reload: in_ready=%b want 1", in_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (g_re[i] !== 32'h3F800000 || g_last[i] !== (i == 7))
                $display("FAIL bp_out%0d: got re=%h last=%b want 3f800000 %b", i, g_re[i], g_last[i], i == 7);
            else n_pass++;
        end
    endtask

    task automatic test_exception;
        set_impulse(32'h3F800000, 32'h0);
        f_re[3] = 32'h7FC00000;
        send_frame();
        wait_valid(lat);
        recv(1'b0);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (g_exc[i] !== 1'b1) $display("FAIL exc_out%0d: got %b want 1", i, g_exc[i]); else n_pass++;
        end
        n_total++; if (exc_sticky !== 1'b1) $display("FAIL exc_sticky_set: got %b want 1", exc_sticky); else n_pass++;
        set_impulse(32'h3F800000, 32'h0);
        send_frame();
        wait_valid(lat);
        recv(1'b0);
        n_total++; if (g_exc[0] !== 1'b0 || g_exc[7] !== 1'b0) $display("FAIL exc_clean: got %b/%b want 0/0", g_exc[0], g_exc[7]); else n_pass++;
        n_total++; if (exc_sticky !== 1'b1) $display("FAIL exc_sticky_hold: got %b want 1", exc_sticky); else n_pass++;
        exc_clr = 1'b1;
        @(posedge clk); #1;
        exc_clr = 1'b0;
        n_total++; if (exc_sticky !== 1'b0) $display("FAIL exc_clr: got %b want 0", exc_sticky); else n_pass++;
        // Clear held across the whole settle window: the capture edge must still set the flag.
        set_impulse(32'h3F800000, 32'h0);
        f_im[6] = 32'h7F800001;
        send_frame();
        exc_clr = 1'b1;
        wait_valid(lat);
        exc_clr = 1'b0;
        n_total++; if (exc_sticky !== 1'b1) $display("FAIL exc_set_wins: got %b want 1", exc_sticky); else n_pass++;
        recv(1'b0);
        exc_clr = 1'b1;
        @(posedge clk); #1;
        exc_clr = 1'b0;
    endtask

    task automatic test_reset_mid_unload;
        set_impulse(32'h3F800000, 32'h0);
        send_frame();
        wait_valid(lat);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b1 || out_last !== 1'b0) $display("FAIL pre_reset: valid=%b last=%b want 1/0", out_valid, out_last); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL async_reset: valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || out_re !== 32'h0) $display("FAIL post_reset: valid=%b re=%h want 0/0", out_valid, out_re); else n_pass++;
        set_impulse(32'h3F800000, 32'h0);
        send_frame();
        wait_valid(lat);
        n_total++; if (lat != 4) $display("FAIL reset_latency: got %0d want 4", lat); else n_pass++;
        recv(1'b0);
        n_total++; if (hs != 8 || g_re[0] !== 32'h3F800000 || g_re[7] !== 32'h3F800000 || g_last[7] !== 1'b1)
            $display("FAIL reset_frame: hs=%0d re0=%h re7=%h last7=%b want 8 3f800000 3f800000 1", hs, g_re[0], g_re[7], g_last[7]);
        else n_pass++;
    endtask

`ifdef FFT8_SEQ_CTRL_IFFT_EN
    task automatic test_ifft;
        set_impulse(32'h0, 32'h3F800000);
        inv = 1'b1;
        send_frame();
        inv = 1'b0;
        n_total++; if (fft_a_re[31:0] !== 32'h3F800000 || fft_a_im[31:0] !== 32'h0)
            $display("FAIL ifft_load_swap: got %h/%h want 3f800000/0", fft_a_re[31:0], fft_a_im[31:0]);
        else n_pass++;
        wait_valid(lat);
        recv(1'b0);
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (g_re[i] !== 32'h0 || g_im[i] !== 32'h3F800000)
                $display("FAIL ifft_out%0d: got %h/%h want 0/3f800000", i, g_re[i], g_im[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_load_map();
        test_dc();
        test_backpressure();
        test_exception();
        test_reset_mid_unload();
`ifdef FFT8_SEQ_CTRL_IFFT_EN
        test_ifft();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
